gearbox_2_to_1: RTL and testbench
=================================

GEARBOX_2_TO_1 -- requirements
Module: gearbox_2_to_1

Interface
REQ-001 The block SHALL have parameter: width, default 8, width of one downstream word; the upstream word is 2*width.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port: up_vld  input  1  upstream word valid.
REQ-005 The block SHALL have port: up_rdy  output  1  block accepts up_data this cycle.
REQ-006 The block SHALL have port: up_data  input  2*width  wide upstream word.
REQ-007 The block SHALL have port: down_vld  output  1  downstream word valid.
REQ-008 The block SHALL have port: down_rdy  input  1  downstream accepts word this cycle.
REQ-009 The block SHALL have port: down_data  output  width  narrow downstream word.

Function
REQ-010 An upstream transfer SHALL occur on a rising edge where up_vld && up_rdy; a downstream transfer SHALL occur where down_vld && down_rdy.
REQ-011 Each accepted wide word SHALL be emitted as two narrow words, up_data[2*width-1:width] first, then up_data[width-1:0], so a 1-to-2 gearbox at the far end reconstructs the original word.
REQ-012 The FSM SHALL have states EMPTY, HIGH (upper half pending), LOW (lower half pending).
REQ-013 Transitions: EMPTY -> HIGH on upstream transfer; HIGH -> LOW on downstream transfer; LOW -> HIGH on downstream transfer with simultaneous upstream transfer; LOW -> EMPTY on downstream transfer without upstream transfer; otherwise hold.
REQ-014 down_vld SHALL be 1 exactly in HIGH or LOW; down_data SHALL be the registered upper half in HIGH, the registered lower half in LOW, and 0 in EMPTY.
REQ-015 up_rdy SHALL be 1 when state is EMPTY, or when state is LOW and down_rdy is 1 (combinational down_rdy -> up_rdy path permitted); 0 otherwise.
REQ-016 The wide data register SHALL load up_data only on an upstream transfer and hold otherwise.
REQ-017 Latency: the first narrow word SHALL appear on down_vld/down_data on the cycle after its wide word is accepted.
REQ-018 Throughput: with up_vld and down_rdy held at 1, the block SHALL sustain one wide word per 2 cycles and down_vld SHALL stay 1 continuously with no bubble.
REQ-019 Back-pressure: while down_vld && !down_rdy, state, down_data and the data register SHALL hold unchanged.
REQ-020 up_vld asserted while up_rdy is 0 SHALL have no effect; up_data is not sampled.
REQ-021 Narrow-word order SHALL be strictly preserved; no word is duplicated or dropped under any combination of up_vld/down_rdy stalls.

Reset
REQ-022 Assertion of rst (low) SHALL immediately, without waiting for clk, force state EMPTY, data register 0, down_vld 0, down_data 0.
REQ-023 up_rdy SHALL be 0 while rst is low and 1 in the first cycle after deassertion.
REQ-024 Reset mid-word, in HIGH or LOW, SHALL discard the pending halves; no part of the discarded word appears after reset.

Structure
REQ-025 The state enum typedef (EMPTY, HIGH, LOW) SHALL live in the shared package gearbox_pkg for reuse by other gearbox blocks.
REQ-026 The block SHALL be a single module with no sub-module; state register, data register and output muxing are local.

Verification
REQ-027 Reset, then up_vld=1, up_data=16'hA1B2, down_rdy=1 for one cycle -> down_data 8'hA1 next cycle, 8'hB2 the cycle after, then down_vld=0.
REQ-028 Back-to-back stream 16'h0102, 16'h0304, 16'h0506 with down_rdy=1 -> down_data 01,02,03,04,05,06 on consecutive cycles; up_rdy pattern 1,0,1,0,1.
REQ-029 Accept 16'hCAFE, hold down_rdy=0 for 5 cycles -> down_vld=1, down_data=8'hCA stable, up_rdy=0 throughout; release -> CA then FE.
REQ-030 Accept 16'h1234, assert rst low asynchronously while in LOW -> down_vld=0 before the next edge; after release, 8'h34 never appears.
REQ-031 Random up_vld/down_rdy (10k cycles, width=8) -> downstream sequence equals the upper/lower split of the accepted upstream words in order; scoreboard empty at end.
REQ-032 Loopback through gearbox_1_to_2 at width=8, random gaps -> reconstructed wide words equal the original upstream words.

Source files
------------

// File: rtl/gearbox_pkg.sv
// Types shared by the gearbox family (2:1, 1:2).
package gearbox_pkg;

  localparam int unsigned GB_STATE_W = 2;

  typedef enum logic [GB_STATE_W-1:0] {
    EMPTY = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2
  } gb_state_e;

endpackage : gearbox_pkg

// File: rtl/gearbox_2_to_1.sv
// Splits each 2*width upstream word into two width-bit downstream words,
// upper half first, with ready/valid handshakes on both sides.
module gearbox_2_to_1
  import gearbox_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_vld,
  output logic                 up_rdy,
  input  logic [2*width-1:0]   up_data,
  output logic                 down_vld,
  input  logic                 down_rdy,
  output logic [width-1:0]     down_data
);

  localparam int unsigned WIDE_W = 2 * width;

  gb_state_e          r_state;
  gb_state_e          w_state_nxt;
  logic [WIDE_W-1:0]  r_data;
  logic [WIDE_W-1:0]  w_data_nxt;
  logic               r_down_vld;
  logic [width-1:0]   r_down_data;
  logic               w_down_vld_nxt;
  logic [width-1:0]   w_down_data_nxt;
  logic               w_up_xfer;
  logic               w_down_xfer;

  assign w_up_xfer   = up_vld && up_rdy;
  assign w_down_xfer = (r_state != EMPTY) && down_rdy;

  // State, wide data register and registered downstream outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_data      <= '0;
      r_down_vld  <= 1'b0;
      r_down_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_down_vld  <= w_down_vld_nxt;
      r_down_data <= w_down_data_nxt;
    end
  end

  // Next state and next wide word
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    if (w_up_xfer) begin
      w_data_nxt = up_data;
    end
    case (r_state)
      EMPTY: if (w_up_xfer)   w_state_nxt = HIGH;
      HIGH:  if (w_down_xfer) w_state_nxt = LOW;
      LOW:   if (w_down_xfer) w_state_nxt = w_up_xfer ? HIGH : EMPTY;
      default:                w_state_nxt = EMPTY;
    endcase
  end

  // Upstream ready and the half selected for the next cycle's output
  always_comb begin
    up_rdy          = rst && ((r_state == EMPTY) || ((r_state == LOW) && down_rdy));
    w_down_vld_nxt  = (w_state_nxt != EMPTY);
    w_down_data_nxt = '0;
    case (w_state_nxt)
      HIGH:    w_down_data_nxt = w_data_nxt[WIDE_W-1:width];
      LOW:     w_down_data_nxt = w_data_nxt[width-1:0];
      default: w_down_data_nxt = '0;
    endcase
  end

  assign down_vld  = r_down_vld;
  assign down_data = r_down_data;

endmodule : gearbox_2_to_1

// File: tb/tb_gearbox_2_to_1.sv
// Self-checking bench for gearbox_2_to_1: directed vector table, corner
// sequences, and a randomized run against a queue-based reference model.
module tb_gearbox_2_to_1;

  localparam int unsigned W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_vld;
  logic          up_rdy;
  logic [2*W-1:0] up_data;
  logic          down_vld;
  logic          down_rdy;
  logic [W-1:0]  down_data;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  gearbox_2_to_1 #(.width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_vld    (up_vld),
    .up_rdy    (up_rdy),
    .up_data   (up_data),
    .down_vld  (down_vld),
    .down_rdy  (down_rdy),
    .down_data (down_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           v;
    logic [2*W-1:0] d;
    logic           r;
    logic           e_rdy;
    logic           e_vld;
    logic [W-1:0]   e_data;
  } vec_t;

  vec_t vecs[12];
  logic [W-1:0] model_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic drive(input logic v, input logic [2*W-1:0] d, input logic r);
    up_vld   = v;
    up_data  = d;
    down_rdy = r;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input logic e_rdy, input logic e_vld, input logic [W-1:0] e_data);
    chk({tag, ".up_rdy"},    32'(up_rdy),    32'(e_rdy));
    chk({tag, ".down_vld"},  32'(down_vld),  32'(e_vld));
    chk({tag, ".down_data"}, 32'(down_data), 32'(e_data));
  endtask

  // One cycle against the model: pending narrow words live in model_q.
  task automatic model_step(input logic v, input logic [2*W-1:0] d, input logic r);
    logic e_rdy;
    logic e_vld;
    logic [W-1:0] e_data;
    drive(v, d, r);
    #2;
    e_vld  = (model_q.size() > 0);
    e_data = e_vld ? model_q[0] : '0;
    e_rdy  = (model_q.size() == 0) || ((model_q.size() == 1) && r);
    check_outs("rand", e_rdy, e_vld, e_data);
    next_cycle();
    if (e_vld && r) void'(model_q.pop_front());
    if (v && e_rdy) begin
      model_q.push_back(d[2*W-1:W]);
      model_q.push_back(d[W-1:0]);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 16'hA1B2, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hA1};
    vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'hB2};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 16'h0102, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b1, 16'h0304, 1'b1, 1'b0, 1'b1, 8'h01};
    vecs[6]  = '{1'b1, 16'h0304, 1'b1, 1'b1, 1'b1, 8'h02};
    vecs[7]  = '{1'b1, 16'h0506, 1'b1, 1'b0, 1'b1, 8'h03};
    vecs[8]  = '{1'b1, 16'h0506, 1'b1, 1'b1, 1'b1, 8'h04};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 8'h05};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 8'h06};
    vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'h00};

    rst = 1'b0;
    drive(1'b1, 16'h5A5A, 1'b1);
    #7;
    check_outs("in_reset", 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Single word and back-to-back stream
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r);
      #2;
      check_outs($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vld, vecs[i].e_data);
      next_cycle();
    end

    // Back-pressure: CA must stay put while down_rdy is low
    drive(1'b1, 16'hCAFE, 1'b1);
    #2; check_outs("bp_acc", 1'b1, 1'b0, 8'h00);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'($urandom), 1'b0);
      #2; check_outs($sformatf("bp_hold%0d", k), 1'b0, 1'b1, 8'hCA);
      next_cycle();
    end
    drive(1'b0, 16'h0000, 1'b1);
    #2; check_outs("bp_rel_hi", 1'b0, 1'b1, 8'hCA);
    next_cycle();
    #2; check_outs("bp_rel_lo", 1'b1, 1'b1, 8'hFE);
    next_cycle();
    #2; check_outs("bp_empty", 1'b1, 1'b0, 8'h00);

    // Asynchronous reset while the lower half is pending
    drive(1'b1, 16'h1234, 1'b1);
    next_cycle();
    drive(1'b0, 16'h0000, 1'b1);
    #2; check_outs("rst_hi", 1'b0, 1'b1, 8'h12);
    next_cycle();
    drive(1'b0, 16'h0000, 1'b0);
    #2; check_outs("rst_lo", 1'b0, 1'b1, 8'h34);
    rst = 1'b0;
    #1; check_outs("rst_async", 1'b0, 1'b0, 8'h00);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 16'h0000, 1'b1);
    #2; check_outs("rst_rel", 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      #2; check_outs($sformatf("rst_after%0d", k), 1'b1, 1'b0, 8'h00);
    end
    next_cycle();

    // Randomized traffic against the queue model
    model_q.delete();
    for (int n = 0; n < 10000; n++) begin
      model_step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 2) != 0));
    end
    for (int n = 0; n < 4; n++) begin
      if (model_q.size() != 0) model_step(1'b0, 16'($urandom), 1'b1);
    end
    chk("scoreboard_empty", 32'(model_q.size()), 32'd0);
    #2; chk("final_down_vld", 32'(down_vld), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_gearbox_2_to_1
